// File: rtl/reg_file_seq_pkg.sv
// rtl/reg_file_seq_pkg.sv - shared opcodes, sequencer states and default widths
package reg_file_seq_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_LDI = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

endpackage

// File: rtl/reg_file_seq_if.sv
// rtl/reg_file_seq_if.sv - instruction handshake between source and sequencer
interface reg_file_seq_if
  import reg_file_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [ADDR_W-1:0] in_rd;
  logic [ADDR_W-1:0] in_rs1;
  logic [ADDR_W-1:0] in_rs2;
  logic [DATA_W-1:0] in_imm;

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm,
    output in_ready
  );

endinterface

// File: rtl/reg_file_seq_alu.sv
// rtl/reg_file_seq_alu.sv - combinational ALU: result and carry/borrow/shift-out
module reg_file_seq_alu
  import reg_file_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: {carry, result} = {1'b0, a} + {1'b0, b};
      // The extra top bit of a wide subtract is the borrow (set when a < b)
      OP_SUB: {carry, result} = {1'b0, a} - {1'b0, b};
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SHL: {carry, result} = {a, 1'b0};
      OP_SHR: {result, carry} = {1'b0, a};
      default: result = imm;
    endcase
  end

endmodule

// File: rtl/reg_file_seq.sv
// rtl/reg_file_seq.sv - IDLE/READ/EXEC/WRITE sequencer that owns the register file ports
module reg_file_seq
  import reg_file_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  reg_file_seq_if.slave     inst,
  output logic [ADDR_W-1:0] rf_raddr1,
  output logic [ADDR_W-1:0] rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              done,
  output logic              flag_z,
  output logic              flag_c
);

  state_t            state;
  logic              ready_q;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              c_q;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;

  assign inst.in_ready = ready_q;

  reg_file_seq_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .imm    (imm_q),
    .result (alu_res),
    .carry  (alu_c)
  );

  // The read addresses double as the latched rs1/rs2, so they are stable for all of READ
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      ready_q   <= 1'b1;
      op_q      <= '0;
      rd_q      <= '0;
      imm_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= 1'b0;
      rf_raddr1 <= '0;
      rf_raddr2 <= '0;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      done      <= 1'b0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
    end else begin
      rf_we <= 1'b0;
      done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (inst.in_valid) begin
            op_q      <= inst.in_op;
            rd_q      <= inst.in_rd;
            imm_q     <= inst.in_imm;
            rf_raddr1 <= inst.in_rs1;
            rf_raddr2 <= inst.in_rs2;
            ready_q   <= 1'b0;
            state     <= ST_READ;
          end
        end
        ST_READ: begin
          a_q   <= rf_rdata1;
          b_q   <= rf_rdata2;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          rf_wdata <= alu_res;
          c_q      <= alu_c;
          rf_waddr <= rd_q;
          rf_we    <= 1'b1;
          done     <= 1'b1;
          state    <= ST_WRITE;
        end
        default: begin
          flag_z  <= (rf_wdata == '0);
          flag_c  <= c_q;
          ready_q <= 1'b1;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_seq.sv
// tb/tb_reg_file_seq.sv - randomized bench with an instruction-level model of the sequencer
module tb_reg_file_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] rf_raddr1, rf_raddr2, rf_waddr;
  logic [7:0] rf_rdata1, rf_rdata2, rf_wdata;
  logic       rf_we, done, flag_z, flag_c;

  reg_file_seq_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  reg_file_seq #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .inst      (bus.slave),
    .rf_raddr1 (rf_raddr1),
    .rf_raddr2 (rf_raddr2),
    .rf_rdata1 (rf_rdata1),
    .rf_rdata2 (rf_rdata2),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .done      (done),
    .flag_z    (flag_z),
    .flag_c    (flag_c)
  );

  always #5 clk = ~clk;

  // 16x8 register file: async reads, falling-edge write
  logic [7:0] regs [16];
  assign rf_rdata1 = regs[rf_raddr1];
  assign rf_rdata2 = regs[rf_raddr2];
  always @(negedge clk) if (rf_we) regs[rf_waddr] <= rf_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Model: each accepted instruction occupies 3 busy cycles; the result lands at the end of the third
  int   mregs [16];
  int   phase = 0;
  int   p_rd, p_rs1, p_rs2, p_res;
  bit   p_c;
  bit   m_z = 0, m_c = 0;
  int   cyc = 0, xfer_cnt = 0, last_xfer_cyc = 0, prev_xfer_cyc = 0, done_cnt = 0;
  bit   chk_en = 0;

  task automatic model_alu(input int op, input int a, input int b, input int imm,
                           output int r, output bit c);
    c = 0;
    case (op)
      0: begin r = a + b; c = (r > 255); end
      1: begin c = (a < b); r = a - b + 256; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = a * 2; c = (r > 255); end
      6: begin c = (a % 2 == 1); r = a / 2; end
      default: r = imm;
    endcase
    r = r % 256;
  endtask

  always @(posedge rst) begin
    phase = 0;
    m_z   = 0;
    m_c   = 0;
  end

  always @(posedge clk) begin
    if (!rst) begin
      cyc++;
      if (phase == 3) begin
        mregs[p_rd] = p_res;
        m_z   = (p_res == 0);
        m_c   = p_c;
        phase = 0;
      end else if (phase != 0) begin
        phase++;
      end else if (bus.in_valid) begin
        p_rd  = int'(bus.in_rd);
        p_rs1 = int'(bus.in_rs1);
        p_rs2 = int'(bus.in_rs2);
        model_alu(int'(bus.in_op), mregs[p_rs1], mregs[p_rs2], int'(bus.in_imm), p_res, p_c);
        phase = 1;
        xfer_cnt++;
        prev_xfer_cyc = last_xfer_cyc;
        last_xfer_cyc = cyc;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      if (done) done_cnt++;
      chk("in_ready", int'(bus.in_ready), int'(phase == 0));
      chk("rf_we",    int'(rf_we),        int'(phase == 3));
      chk("done",     int'(done),         int'(phase == 3));
      chk("flag_z",   int'(flag_z),       int'(m_z));
      chk("flag_c",   int'(flag_c),       int'(m_c));
      if (phase == 1) begin
        chk("rf_raddr1", int'(rf_raddr1), p_rs1);
        chk("rf_raddr2", int'(rf_raddr2), p_rs2);
      end
      if (phase == 3) begin
        chk("rf_waddr", int'(rf_waddr), p_rd);
        chk("rf_wdata", int'(rf_wdata), p_res);
      end
    end
  end

  task automatic drive(input int op, input int rd, input int rs1, input int rs2, input int imm);
    bus.in_op  = 3'(op);
    bus.in_rd  = 4'(rd);
    bus.in_rs1 = 4'(rs1);
    bus.in_rs2 = 4'(rs2);
    bus.in_imm = 8'(imm);
  endtask

  task automatic drive_rand();
    drive(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
          int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
  endtask

  task automatic run_op(input int op, input int rd, input int rs1, input int rs2, input int imm);
    int x0, g, lows, dones;
    @(negedge clk);
    drive(op, rd, rs1, rs2, imm);
    bus.in_valid = 1'b1;
    x0 = xfer_cnt;
    g  = 0;
    while (xfer_cnt == x0 && g < 20) begin
      @(negedge clk);
      g++;
    end
    bus.in_valid = 1'b0;
    chk("xfer_taken", xfer_cnt - x0, 1);
    lows  = 0;
    dones = 0;
    g     = 0;
    while (!bus.in_ready && g < 20) begin
      lows++;
      if (done) dones++;
      @(negedge clk);
      g++;
    end
    chk("ready_low_cycles", lows, 3);
    chk("done_pulses", dones, 1);
  endtask

  task automatic stream(input int n);
    int x0, d0, seen, g;
    @(negedge clk);
    drive_rand();
    bus.in_valid = 1'b1;
    x0   = xfer_cnt;
    d0   = done_cnt;
    seen = xfer_cnt;
    g    = 0;
    while (xfer_cnt - x0 < n && g < n * 6 + 10) begin
      @(negedge clk);
      g++;
      if (xfer_cnt != seen) begin
        seen = xfer_cnt;
        if (xfer_cnt - x0 > 1) chk("xfer_gap", last_xfer_cyc - prev_xfer_cyc, 4);
        drive_rand();
      end
    end
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("stream_xfers", xfer_cnt - x0, n);
    chk("stream_dones", done_cnt - d0, n);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      regs[i]  = 8'h00;
      mregs[i] = 0;
    end
    bus.in_valid = 1'b0;
    drive(0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_rf_we",    int'(rf_we), 0);
    chk("rst_done",     int'(done), 0);
    chk("rst_flags",    int'({flag_z, flag_c}), 0);
    chk("rst_addrs",    int'({rf_raddr1, rf_raddr2, rf_waddr}), 0);
    chk("rst_wdata",    int'(rf_wdata), 0);
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;

    run_op(7, 1, 0, 0, 8'h3C);
    run_op(7, 2, 0, 0, 8'h0F);
    chk("lit_r1", int'(regs[1]), 8'h3C);
    chk("lit_r2", int'(regs[2]), 8'h0F);
    run_op(0, 3, 1, 2, 0);
    chk("lit_r3", int'(regs[3]), 8'h4B);
    chk("lit_add_zc", int'({flag_z, flag_c}), 2'b00);
    run_op(7, 4, 0, 0, 8'hFF);
    run_op(7, 5, 0, 0, 8'h01);
    run_op(0, 6, 4, 5, 0);
    chk("lit_r6", int'(regs[6]), 8'h00);
    chk("lit_add_wrap_zc", int'({flag_z, flag_c}), 2'b11);
    run_op(1, 7, 5, 4, 0);
    chk("lit_r7", int'(regs[7]), 8'h02);
    chk("lit_sub_zc", int'({flag_z, flag_c}), 2'b01);
    run_op(2, 11, 1, 2, 0);
    chk("lit_and", int'(regs[11]), 8'h0C);
    chk("lit_and_c", int'(flag_c), 0);
    run_op(3, 12, 1, 2, 0);
    chk("lit_or", int'(regs[12]), 8'h3F);
    run_op(4, 13, 1, 2, 0);
    chk("lit_xor", int'(regs[13]), 8'h33);
    run_op(5, 8, 4, 0, 0);
    chk("lit_shl", int'(regs[8]), 8'hFE);
    chk("lit_shl_c", int'(flag_c), 1);
    run_op(6, 9, 5, 0, 0);
    chk("lit_shr", int'(regs[9]), 8'h00);
    chk("lit_shr_zc", int'({flag_z, flag_c}), 2'b11);
    run_op(0, 1, 1, 1, 0);
    chk("lit_rd_eq_rs", int'(regs[1]), 8'h78);

    for (int i = 0; i < 40; i++) begin
      run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
    end
    stream(60);

    // Reset while the ADD into r10 sits in EXEC: its write must never land
    run_op(7, 10, 0, 0, 8'h55);
    @(negedge clk);
    drive(0, 10, 1, 2, 0);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_exec_in_ready", int'(bus.in_ready), 1);
    chk("rst_exec_rf_we",    int'(rf_we), 0);
    chk("rst_exec_done",     int'(done), 0);
    chk("rst_exec_flags",    int'({flag_z, flag_c}), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("lit_r10_kept", int'(regs[10]), 8'h55);
    run_op(7, 14, 0, 0, 8'hA5);
    chk("lit_r14_after_rst", int'(regs[14]), 8'hA5);

    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) chk($sformatf("regfile_r%0d", i), int'(regs[i]), mregs[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_seq.md
Name: reg_file_seq

Overview:
- Micro-op sequencer that owns both read ports and the write port of the 16x8 dual-read register file.
- Accepts one register-to-register instruction per handshake and reads the operands through the two async read ports.
- Executes the op in an internal ALU and writes the result back with a single-cycle write-enable that spans the file's falling-edge write.
- Sits between the instruction source (test bench or future decoder) and the register file; the only writer of the file.

Parameters:
DATA_W, 8, data width; must match register file word width
ADDR_W, 4, register address width (16 registers)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  instruction present
in_ready  output  1  sequencer can accept an instruction
in_op  input  3  opcode
in_rd  input  ADDR_W  destination register
in_rs1  input  ADDR_W  source register 1
in_rs2  input  ADDR_W  source register 2
in_imm  input  DATA_W  immediate (LDI only)
rf_raddr1  output  ADDR_W  to register file raddr1
rf_raddr2  output  ADDR_W  to register file raddr2
rf_rdata1  input  DATA_W  from register file rdata1
rf_rdata2  input  DATA_W  from register file rdata2
rf_we  output  1  to register file write enable
rf_waddr  output  ADDR_W  to register file write address
rf_wdata  output  DATA_W  to register file write data
done  output  1  one-cycle pulse: result being written
flag_z  output  1  last result == 0
flag_c  output  1  last carry/borrow/shift-out

Behaviour:
- Reset (async, immediate): state IDLE; in_ready=1; rf_we=0, done=0, flags=0; all address/data outputs 0; latched instruction cleared.
- States: IDLE -> READ -> EXEC -> WRITE -> IDLE; one cycle each except IDLE.
- IDLE: in_ready=1. Transfer = in_valid & in_ready at a rising edge. On transfer, latch op/rd/rs1/rs2/imm and go to READ. in_valid without transfer: no effect.
- READ: rf_raddr1/2 driven from latched rs1/rs2 (registered, stable the whole cycle). At the end of the cycle, capture rf_rdata1/2 into operand registers A/B.
- EXEC: compute result and carry from A, B, imm. Register them into rf_wdata and a carry holding register; rf_waddr = rd.
- WRITE: rf_we=1 and done=1 for exactly this cycle; rf_waddr/rf_wdata held stable the whole cycle, so the file's negedge captures them. flag_z/flag_c update at the end of this cycle. Next state IDLE.
- in_ready=0 in READ/EXEC/WRITE. Latency is 3 cycles from the transfer edge to the end of WRITE. Max throughput is one instruction per 4 cycles.
- Opcodes and carry rules; all arithmetic in DATA_W bits, result truncated:
  - 0 ADD: A+B; c=carry out
  - 1 SUB: A-B; c=borrow (A<B)
  - 2 AND, 3 OR, 4 XOR: c=0
  - 5 SHL: A<<1; c=A[7]
  - 6 SHR: A>>1 logical; c=A[0]
  - 7 LDI: imm; c=0; READ still executes, operands ignored
- Boundaries:
  - rd equal to rs1/rs2 is legal; sources are read before the write.
  - ADD 0xFF+0x01 gives 0x00 with z=1, c=1.
  - SUB 0x00-0x01 gives 0xFF with c=1.
  - rst during WRITE drops rf_we asynchronously; that write may or may not land; no done pulse.
  - Inputs are ignored outside IDLE.
- Outputs are never X after reset; rf_we is only high in WRITE.

Decomposition:
- Package reg_file_seq_pkg: opcode localparams (OP_ADD..OP_LDI), state encoding (ST_IDLE, ST_READ, ST_EXEC, ST_WRITE), DATA_W/ADDR_W defaults.
- One combinational sub-module, reg_file_seq_alu: inputs op, A, B, imm; outputs result and carry.
- The FSM, handshake and register-file drive stay in the top.

Test Plan:
- Reset, then LDI r1=0x3C, LDI r2=0x0F -> done once per op; r1=0x3C, r2=0x0F; in_ready low for exactly 3 cycles after each transfer.
- ADD r3=r1+r2 -> r3=0x4B, z=0, c=0. Then LDI r4=0xFF, LDI r5=0x01, ADD r6=r4+r5 -> r6=0x00, z=1, c=1.
- SUB r7=r5-r4 (0x01-0xFF) -> r7=0x02, c=1. AND/OR/XOR r1,r2 -> 0x0C / 0x3F / 0x33, c=0.
- SHL r8=r4 -> 0xFE, c=1. SHR r9=r5 -> 0x00, z=1, c=1. ADD r1=r1+r1 (rd==rs) -> r1=0x78.
- Hold in_valid high continuously with back-to-back ops -> one transfer per 4 cycles; no op lost or duplicated; rf_we pulses are exactly 1 cycle and 4 cycles apart.
- Assert rst during EXEC of an ADD into r10 (previously 0x55) -> in_ready=1 and rf_we=0 immediately; r10 stays 0x55; flags=0; the next LDI completes normally.
